// File: rtl/alu_8bit.sv
// 8-bit datapath ALU: combinational result with a registered carry flag and scratch register.
// Zero-cycle result latency; C/R update on the rising edge; no handshake, one operation per cycle.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_1,
    input  logic [7:0] i_2,
    input  logic [2:0] op_code,
    input  logic       carry_ce,
    output logic [7:0] o_main,
    output logic       carry_out
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_WRITE = 3'b110;
    localparam logic [2:0] OP_READ  = 3'b111;

    logic       c_q, c_d;
    logic [7:0] r_q, r_d;
    logic       cin;
    logic [8:0] sum9;
    logic [8:0] diff9;

    assign cin   = carry_ce & c_q;
    assign sum9  = {1'b0, i_1} + {1'b0, i_2} + {8'd0, cin};
    // A negative 9-bit difference sets bit 8, which is exactly the borrow.
    assign diff9 = {1'b0, i_1} - {1'b0, i_2} - {8'd0, cin};

    always_comb begin
        o_main    = 8'd0;
        carry_out = 1'b0;
        case (op_code)
            OP_ADD:   {carry_out, o_main} = sum9;
            OP_SUB:   {carry_out, o_main} = diff9;
            OP_AND:   o_main = i_1 & i_2;
            OP_OR:    o_main = i_1 | i_2;
            OP_XOR:   o_main = i_1 ^ i_2;
            OP_NOT:   o_main = ~i_1;
            OP_WRITE: o_main = i_1;
            OP_READ:  o_main = r_q;
            default:  o_main = 8'd0;
        endcase
    end

    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (op_code == OP_ADD || op_code == OP_SUB) begin
            c_d = carry_out;
        end
        if (op_code == OP_WRITE) begin
            r_d = i_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            r_q <= 8'd0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: one task per feature, hand-computed expectations.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] i_1;
    logic [7:0] i_2;
    logic [2:0] op_code;
    logic       carry_ce;
    logic [7:0] o_main;
    logic       carry_out;

    int total = 0;
    int bad   = 0;

    alu_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .i_1       (i_1),
        .i_2       (i_2),
        .op_code   (op_code),
        .carry_ce  (carry_ce),
        .o_main    (o_main),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call is one cycle: advance past the edge that commits the previous op,
    // apply the new op, then settle to the falling edge for sampling.
    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ce, input logic r);
        @(posedge clk);
        #1;
        op_code  = op;
        i_1      = a;
        i_2      = b;
        carry_ce = ce;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(3'b000, 8'd0, 8'd0, 1'b0, 1'b1);
        drive(3'b000, 8'd0, 8'd0, 1'b0, 1'b1);
        drive(3'b111, 8'h5A, 8'hA5, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0) begin
            bad++;
            $display("FAIL reset_r: got %0d expected 0", o_main);
        end
        drive(3'b000, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_c: got %0d/%0b expected 0/0", o_main, carry_out);
        end
    endtask

    task automatic test_add();
        drive(3'b000, 8'd2, 8'd3, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd5 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL add_2_3: got %0d/%0b expected 5/0", o_main, carry_out);
        end
        drive(3'b000, 8'd128, 8'd128, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL add_128_128: got %0d/%0b expected 0/1", o_main, carry_out);
        end
        drive(3'b000, 8'd128, 8'd0, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd128 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL add_128_0: got %0d/%0b expected 128/0", o_main, carry_out);
        end
    endtask

    task automatic test_sub();
        drive(3'b001, 8'd3, 8'd3, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL sub_3_3: got %0d/%0b expected 0/0", o_main, carry_out);
        end
        drive(3'b001, 8'd2, 8'd3, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd255 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL sub_2_3: got %0d/%0b expected 255/1", o_main, carry_out);
        end
    endtask

    task automatic test_logic();
        // Carry is 1 from the preceding borrow; carry_ce must not leak into logic ops.
        drive(3'b010, 8'b0100_1010, 8'b1111_0111, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'b0100_0010 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL and: got %b/%0b expected 01000010/0", o_main, carry_out);
        end
        drive(3'b011, 8'b0100_0010, 8'b0000_1000, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'b0100_1010 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL or: got %b/%0b expected 01001010/0", o_main, carry_out);
        end
        drive(3'b100, 8'b0100_0010, 8'b0000_1000, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'b0100_1010 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL xor: got %b/%0b expected 01001010/0", o_main, carry_out);
        end
        drive(3'b101, 8'b0111_1111, 8'hC3, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'b1000_0000 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL not: got %b/%0b expected 10000000/0", o_main, carry_out);
        end
        // Flag set by SUB 2-3 must have survived the four logic ops.
        drive(3'b000, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd1 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL c_hold: got %0d/%0b expected 1/0", o_main, carry_out);
        end
    endtask

    task automatic test_carry_chain();
        drive(3'b000, 8'd255, 8'd1, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL add_255_1: got %0d/%0b expected 0/1", o_main, carry_out);
        end
        drive(3'b000, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd1 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL adc_chain: got %0d/%0b expected 1/0", o_main, carry_out);
        end
        drive(3'b001, 8'd0, 8'd1, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd255 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL sub_0_1: got %0d/%0b expected 255/1", o_main, carry_out);
        end
        drive(3'b001, 8'd5, 8'd1, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd3 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL sbb_chain: got %0d/%0b expected 3/0", o_main, carry_out);
        end
        drive(3'b000, 8'd255, 8'd1, 1'b0, 1'b0);
        drive(3'b000, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL add_noce: got %0d/%0b expected 0/0", o_main, carry_out);
        end
        drive(3'b001, 8'd0, 8'd1, 1'b0, 1'b0);
        drive(3'b001, 8'd5, 8'd1, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd4 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL sub_noce: got %0d/%0b expected 4/0", o_main, carry_out);
        end
    endtask

    task automatic test_register();
        drive(3'b110, 8'd3, 8'd99, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd3 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reg_write: got %0d/%0b expected 3/0", o_main, carry_out);
        end
        drive(3'b111, 8'd77, 8'd88, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd3 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reg_read: got %0d/%0b expected 3/0", o_main, carry_out);
        end
    endtask

    task automatic test_mid_reset();
        // Arm C=1, then reset on a cycle that also attempts a REG_WRITE.
        drive(3'b000, 8'd255, 8'd1, 1'b0, 1'b0);
        drive(3'b110, 8'hAA, 8'd0, 1'b0, 1'b1);
        total++;
        if (o_main !== 8'hAA) begin
            bad++;
            $display("FAIL rst_passthru: got %h expected aa", o_main);
        end
        drive(3'b111, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if (o_main !== 8'd0) begin
            bad++;
            $display("FAIL rst_r_clear: got %0d expected 0", o_main);
        end
        drive(3'b000, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if (o_main !== 8'd0 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_c_clear: got %0d/%0b expected 0/0", o_main, carry_out);
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_1      = 8'd0;
        i_2      = 8'd0;
        op_code  = 3'b000;
        carry_ce = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_carry_chain();
        test_register();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
